// File: rtl/tx_ltssm_os_gen.sv
// ---------------------------------------------------------------------------
// tx_ltssm_os_gen
// Transmit-side LTSSM ordered-set generator. Builds TS1/TS2/EIOS/EIEOS sets
// for up to MAX_LANES lanes (one 128-bit set per lane) in 8b/10b symbol form
// (Gen1/2) or 128b/130b form (Gen3+). It counts accepted sets and pulses
// finish once the requested number has been sent. At Gen3+ an EIEOS is forced
// after every EIEOS_INTERVAL accepted TS1/TS2 sets.
//
// Ports
//   clk, reset (async, active low)
//   Gen, start, stop, osType, numToSend        burst control from the LTSSM
//   linkNumber, useLinkNumber, useLaneNumber,
//   numberOfDetectedLanes, rateId, nFts,
//   trainingControl                            set contents
//   txReady                                    PIPE side accepts current set
//   orderedSets, validOrderedSets              per-lane sets to PIPE
//   busy, finish, sentCount                    status back to the LTSSM
// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | waiting for start; outputs invalid
// SEND  | a set is presented; advances on txReady
// DONE  | final set accepted; finish high for this one cycle
// ---------------------------------------------------------------------------
module tx_ltssm_os_gen #(
    parameter int DEVICETYPE     = 0,
    parameter int MAX_LANES      = 16,
    parameter int EIEOS_INTERVAL = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2:0]                 Gen,
    input  logic                       start,
    input  logic                       stop,
    input  logic [1:0]                 osType,
    input  logic [15:0]                numToSend,
    input  logic [7:0]                 linkNumber,
    input  logic                       useLinkNumber,
    input  logic                       useLaneNumber,
    input  logic [4:0]                 numberOfDetectedLanes,
    input  logic [7:0]                 rateId,
    input  logic [7:0]                 nFts,
    input  logic [3:0]                 trainingControl,
    input  logic                       txReady,
    output logic [MAX_LANES*128-1:0]   orderedSets,
    output logic                       validOrderedSets,
    output logic                       busy,
    output logic                       finish,
    output logic [15:0]                sentCount
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] OS_TS1   = 2'd0;
    localparam logic [1:0] OS_TS2   = 2'd1;
    localparam logic [1:0] OS_EIOS  = 2'd2;
    localparam logic [1:0] OS_EIEOS = 2'd3;

    localparam int CW = $clog2(EIEOS_INTERVAL + 1);

    logic [1:0]  state;

    // Burst snapshot, captured on start
    logic [2:0]  genS;
    logic [1:0]  osTypeS;
    logic [15:0] numS;
    logic [7:0]  linkS;
    logic        useLinkS;
    logic        useLaneS;
    logic [4:0]  lanesS;
    logic [7:0]  rateS;
    logic [7:0]  nFtsS;
    logic [3:0]  tcS;

    logic [CW-1:0] eieosCnt;
    logic          curInsert;   // set on the wire is a forced EIEOS

    logic [2:0]  selGen;
    logic [1:0]  selType;
    logic [7:0]  selLink;
    logic        selUseLink;
    logic        selUseLane;
    logic [4:0]  selLanes;
    logic [7:0]  selRate;
    logic [7:0]  selNFts;
    logic [3:0]  selTc;
    logic        countsTs;
    logic [CW-1:0] eieosInc;
    logic        insertNow;
    logic        lastSet;
    logic [MAX_LANES*128-1:0] nextSets;

    function automatic logic [127:0] buildLane(
        input logic [2:0] gen,
        input logic [1:0] ty,
        input logic [7:0] laneNum,
        input logic [7:0] link,
        input logic       useLink,
        input logic       useLane,
        input logic [7:0] rate,
        input logic [7:0] fts,
        input logic [3:0] tc
    );
        logic [127:0] res;
        logic         hiRate;
        logic [7:0]   tcByte;
        hiRate = (gen >= 3'd3);
        // A downstream port never advertises training-control bit 3
        tcByte = {4'b0000, (DEVICETYPE == 1) ? 1'b0 : tc[3], tc[2:0]};
        res    = '0;
        case (ty)
            OS_TS1, OS_TS2: begin
                for (int k = 6; k < 16; k++) begin
                    if (hiRate && k < 10)
                        res[k*8 +: 8] = 8'h00;
                    else
                        res[k*8 +: 8] = (ty == OS_TS1) ? 8'h4A : 8'h45;
                end
                if (hiRate)
                    res[7:0] = (ty == OS_TS1) ? 8'h1E : 8'h2D;
                else
                    res[7:0] = 8'hBC;
                res[15:8]  = useLink ? link : 8'hF7;
                res[23:16] = useLane ? laneNum : 8'hF7;
                res[31:24] = fts;
                res[39:32] = rate;
                res[47:40] = tcByte;
            end
            OS_EIOS: begin
                for (int k = 0; k < 16; k++)
                    res[k*8 +: 8] = hiRate ? 8'h66 : ((k == 0) ? 8'hBC : 8'h7C);
            end
            default: begin
                for (int k = 0; k < 16; k++) begin
                    if (hiRate)
                        res[k*8 +: 8] = (k % 2 == 1) ? 8'hFF : 8'h00;
                    else if (k == 0)
                        res[k*8 +: 8] = 8'hBC;
                    else if (k == 15)
                        res[k*8 +: 8] = 8'h4A;
                    else
                        res[k*8 +: 8] = 8'hFC;
                end
            end
        endcase
        return res;
    endfunction

    // In IDLE the first set is built straight from the inputs so it can be
    // loaded on the start edge; afterwards only the snapshot is used.
    always_comb begin
        selGen     = (state == IDLE) ? Gen                   : genS;
        selLink    = (state == IDLE) ? linkNumber            : linkS;
        selUseLink = (state == IDLE) ? useLinkNumber         : useLinkS;
        selUseLane = (state == IDLE) ? useLaneNumber         : useLaneS;
        selLanes   = (state == IDLE) ? numberOfDetectedLanes : lanesS;
        selRate    = (state == IDLE) ? rateId                : rateS;
        selNFts    = (state == IDLE) ? nFts                  : nFtsS;
        selTc      = (state == IDLE) ? trainingControl       : tcS;

        countsTs  = (genS >= 3'd3) && ((osTypeS == OS_TS1) || (osTypeS == OS_TS2));
        eieosInc  = eieosCnt + CW'(1);
        insertNow = countsTs && !curInsert && (eieosInc == CW'(EIEOS_INTERVAL));
        lastSet   = (numS != 16'd0) && (({1'b0, sentCount} + 17'd1) == {1'b0, numS});

        if (state == IDLE)
            selType = osType;
        else if (insertNow)
            selType = OS_EIEOS;
        else
            selType = osTypeS;

        nextSets = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < int'(selLanes))
                nextSets[i*128 +: 128] = buildLane(selGen, selType, 8'(i), selLink,
                                                   selUseLink, selUseLane, selRate,
                                                   selNFts, selTc);
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            orderedSets      <= '0;
            validOrderedSets <= 1'b0;
            finish           <= 1'b0;
            sentCount        <= 16'd0;
            eieosCnt         <= '0;
            curInsert        <= 1'b0;
            genS             <= 3'd0;
            osTypeS          <= 2'd0;
            numS             <= 16'd0;
            linkS            <= 8'd0;
            useLinkS         <= 1'b0;
            useLaneS         <= 1'b0;
            lanesS           <= 5'd0;
            rateS            <= 8'd0;
            nFtsS            <= 8'd0;
            tcS              <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    finish <= 1'b0;
                    if (start && !stop) begin
                        genS             <= Gen;
                        osTypeS          <= osType;
                        numS             <= numToSend;
                        linkS            <= linkNumber;
                        useLinkS         <= useLinkNumber;
                        useLaneS         <= useLaneNumber;
                        lanesS           <= numberOfDetectedLanes;
                        rateS            <= rateId;
                        nFtsS            <= nFts;
                        tcS              <= trainingControl;
                        sentCount        <= 16'd0;
                        eieosCnt         <= '0;
                        curInsert        <= 1'b0;
                        orderedSets      <= nextSets;
                        validOrderedSets <= 1'b1;
                        state            <= SEND;
                    end
                end
                SEND: begin
                    if (stop) begin
                        state            <= IDLE;
                        validOrderedSets <= 1'b0;
                        orderedSets      <= '0;
                        curInsert        <= 1'b0;
                    end else if (txReady) begin
                        if (curInsert) begin
                            // Forced EIEOS is not counted; it restarts the interval
                            eieosCnt    <= '0;
                            curInsert   <= 1'b0;
                            orderedSets <= nextSets;
                        end else begin
                            if (sentCount != 16'hFFFF)
                                sentCount <= sentCount + 16'd1;
                            if (lastSet) begin
                                state            <= DONE;
                                validOrderedSets <= 1'b0;
                                orderedSets      <= '0;
                                finish           <= 1'b1;
                            end else begin
                                orderedSets <= nextSets;
                                if (countsTs)
                                    eieosCnt <= eieosInc;
                                curInsert <= insertNow;
                            end
                        end
                    end
                end
                DONE: begin
                    finish <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state            <= IDLE;
                    validOrderedSets <= 1'b0;
                    finish           <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_ltssm_os_gen.sv
module tb_tx_ltssm_os_gen;

    localparam int NL = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [2:0]      Gen = 3'd1;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic [1:0]      osType = 2'd0;
    logic [15:0]     numToSend = 16'd0;
    logic [7:0]      linkNumber = 8'd0;
    logic            useLinkNumber = 1'b1;
    logic            useLaneNumber = 1'b1;
    logic [4:0]      numberOfDetectedLanes = 5'd4;
    logic [7:0]      rateId = 8'h02;
    logic [7:0]      nFts = 8'h20;
    logic [3:0]      trainingControl = 4'b1010;
    logic            txReady = 1'b0;
    logic [NL*128-1:0] orderedSets;
    logic            validOrderedSets;
    logic            busy;
    logic            finish;
    logic [15:0]     sentCount;

    int checks = 0;
    int failures = 0;
    logic [NL*128-1:0] expQ [$];

    tx_ltssm_os_gen #(.DEVICETYPE(0), .MAX_LANES(NL), .EIEOS_INTERVAL(32)) dut (
        .clk(clk), .reset(reset), .Gen(Gen), .start(start), .stop(stop),
        .osType(osType), .numToSend(numToSend), .linkNumber(linkNumber),
        .useLinkNumber(useLinkNumber), .useLaneNumber(useLaneNumber),
        .numberOfDetectedLanes(numberOfDetectedLanes), .rateId(rateId),
        .nFts(nFts), .trainingControl(trainingControl), .txReady(txReady),
        .orderedSets(orderedSets), .validOrderedSets(validOrderedSets),
        .busy(busy), .finish(finish), .sentCount(sentCount)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] modelLane(input logic [2:0] g, input logic [1:0] ty,
                                               input int lane, input logic [7:0] link,
                                               input logic ul, input logic un,
                                               input logic [7:0] rate, input logic [7:0] fts,
                                               input logic [3:0] tc);
        logic [7:0]   b [16];
        logic [127:0] r;
        logic         g3;
        g3 = (g >= 3'd3);
        for (int k = 0; k < 16; k++) b[k] = 8'h00;
        if (ty == 2'd0 || ty == 2'd1) begin
            for (int k = 0; k < 16; k++) b[k] = (ty == 2'd0) ? 8'h4A : 8'h45;
            if (g3) for (int k = 6; k <= 9; k++) b[k] = 8'h00;
            b[0] = g3 ? ((ty == 2'd0) ? 8'h1E : 8'h2D) : 8'hBC;
            b[1] = ul ? link : 8'hF7;
            b[2] = un ? 8'(lane) : 8'hF7;
            b[3] = fts;
            b[4] = rate;
            b[5] = {4'h0, tc};
        end else if (ty == 2'd2) begin
            for (int k = 0; k < 16; k++) b[k] = g3 ? 8'h66 : 8'h7C;
            if (!g3) b[0] = 8'hBC;
        end else begin
            if (g3) begin
                for (int k = 1; k < 16; k += 2) b[k] = 8'hFF;
            end else begin
                for (int k = 0; k < 16; k++) b[k] = 8'hFC;
                b[0]  = 8'hBC;
                b[15] = 8'h4A;
            end
        end
        for (int k = 0; k < 16; k++) r[k*8 +: 8] = b[k];
        return r;
    endfunction

    function automatic logic [NL*128-1:0] modelSets(input logic [1:0] ty);
        logic [NL*128-1:0] s;
        s = '0;
        for (int l = 0; l < NL; l++)
            if (l < int'(numberOfDetectedLanes))
                s[l*128 +: 128] = modelLane(Gen, ty, l, linkNumber, useLinkNumber,
                                            useLaneNumber, rateId, nFts, trainingControl);
        return s;
    endfunction

    task automatic pushN(input int n, input logic [1:0] ty);
        for (int i = 0; i < n; i++) expQ.push_back(modelSets(ty));
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // start sampled on the posedge just before return; returns 1 time unit after it
    task automatic launch();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Scoreboard: every set accepted by the PIPE side is compared against the queue
    logic [NL*128-1:0] scExp;
    int scBad;
    always @(negedge clk) begin
        if (reset && validOrderedSets && txReady && !stop) begin
            checks++;
            assert (expQ.size() > 0) else begin
                failures++;
                $error("FAIL sb_underflow observed=unexpected_set expected=none");
            end
            if (expQ.size() > 0) begin
                scExp = expQ.pop_front();
                scBad = 0;
                for (int l = NL - 1; l >= 0; l--)
                    if (orderedSets[l*128 +: 128] !== scExp[l*128 +: 128]) scBad = l;
                checks++;
                assert (orderedSets === scExp) else begin
                    failures++;
                    $error("FAIL sb_set lane=%0d observed=%032h expected=%032h", scBad,
                           orderedSets[scBad*128 +: 128], scExp[scBad*128 +: 128]);
                end
            end
        end
    end

    logic [NL*128-1:0] held;
    int validCnt;
    int cyc;
    logic sawFinish;

    initial begin
        // reset state
        #12;
        chk("rst_valid", 64'(validOrderedSets), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_finish", 64'(finish), 64'd0);
        chk("rst_count", 64'(sentCount), 64'd0);
        chk("rst_sets_zero", 64'(orderedSets != '0), 64'd0);
        reset = 1'b1;

        // start and stop together in IDLE: nothing happens
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        tick();
        chk("startstop_busy", 64'(busy), 64'd0);
        chk("startstop_valid", 64'(validOrderedSets), 64'd0);

        // 1: Gen1 TS1, 4 lanes, three sets back to back
        Gen = 3'd1; osType = 2'd0; numToSend = 16'd3; linkNumber = 8'h05;
        useLinkNumber = 1'b1; useLaneNumber = 1'b1; numberOfDetectedLanes = 5'd4;
        txReady = 1'b1;
        pushN(3, 2'd0);
        launch();
        chk("t1_valid_first", 64'(validOrderedSets), 64'd1);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_l2_sym1", 64'(orderedSets[2*128 + 8 +: 8]), 64'h05);
        chk("t1_l2_sym2", 64'(orderedSets[2*128 + 16 +: 8]), 64'h02);
        chk("t1_l2_sym6", 64'(orderedSets[2*128 + 48 +: 8]), 64'h4A);
        chk("t1_l0_sym5", 64'(orderedSets[40 +: 8]), 64'h0A);
        chk("t1_hi_lanes_zero", 64'(orderedSets[NL*128-1:512] != '0), 64'd0);
        tick();
        tick();
        chk("t1_valid_third", 64'(validOrderedSets), 64'd1);
        chk("t1_no_early_finish", 64'(finish), 64'd0);
        tick();
        chk("t1_finish", 64'(finish), 64'd1);
        chk("t1_valid_done", 64'(validOrderedSets), 64'd0);
        chk("t1_count", 64'(sentCount), 64'd3);
        tick();
        chk("t1_finish_one_cycle", 64'(finish), 64'd0);
        chk("t1_idle", 64'(busy), 64'd0);
        chk("t1_count_hold", 64'(sentCount), 64'd3);
        chk("t1_queue_empty", 64'(expQ.size()), 64'd0);

        // 2: Gen1 TS2, PAD link, txReady 1,0,1; inputs change after start
        Gen = 3'd1; osType = 2'd1; numToSend = 16'd2; useLinkNumber = 1'b0;
        numberOfDetectedLanes = 5'd1;
        txReady = 1'b1;
        pushN(2, 2'd1);
        launch();
        osType = 2'd0; useLinkNumber = 1'b1; linkNumber = 8'h09;
        chk("t2_sym1_pad", 64'(orderedSets[15:8]), 64'hF7);
        tick();
        txReady = 1'b0;
        held = orderedSets;
        chk("t2_count_one", 64'(sentCount), 64'd1);
        tick();
        chk("t2_held_stable", 64'(orderedSets !== held), 64'd0);
        chk("t2_valid_held", 64'(validOrderedSets), 64'd1);
        chk("t2_count_hold", 64'(sentCount), 64'd1);
        txReady = 1'b1;
        tick();
        chk("t2_finish", 64'(finish), 64'd1);
        chk("t2_count", 64'(sentCount), 64'd2);
        tick();

        // 3: Gen3 TS1 x40, EIEOS forced after 32
        Gen = 3'd3; osType = 2'd0; numToSend = 16'd40; linkNumber = 8'h05;
        useLinkNumber = 1'b1; useLaneNumber = 1'b1; numberOfDetectedLanes = 5'd16;
        txReady = 1'b1;
        pushN(32, 2'd0);
        pushN(1, 2'd3);
        pushN(8, 2'd0);
        launch();
        validCnt = 0; cyc = 0;
        while (finish !== 1'b1 && cyc < 100) begin
            if (validOrderedSets) validCnt++;
            tick();
            cyc++;
        end
        chk("t3_finish_seen", 64'(finish), 64'd1);
        chk("t3_valid_cycles", 64'(validCnt), 64'd41);
        chk("t3_count", 64'(sentCount), 64'd40);
        chk("t3_queue_empty", 64'(expQ.size()), 64'd0);
        tick();

        // 4: Gen3 EIOS, single set on 8 lanes
        Gen = 3'd3; osType = 2'd2; numToSend = 16'd1; numberOfDetectedLanes = 5'd8;
        txReady = 1'b1;
        pushN(1, 2'd2);
        launch();
        chk("t4_l7_sym15", 64'(orderedSets[7*128 + 120 +: 8]), 64'h66);
        chk("t4_l8_zero", 64'(orderedSets[8*128 +: 128]), 64'd0);
        tick();
        chk("t4_finish", 64'(finish), 64'd1);
        chk("t4_count", 64'(sentCount), 64'd1);
        tick();

        // 5: continuous Gen1 TS1, stop after 5 accepts (stop beats accept)
        Gen = 3'd1; osType = 2'd0; numToSend = 16'd0; numberOfDetectedLanes = 5'd2;
        txReady = 1'b1;
        sawFinish = 1'b0;
        pushN(5, 2'd0);
        launch();
        for (int i = 0; i < 5; i++) begin
            tick();
            sawFinish = sawFinish | finish;
        end
        chk("t5_count_pre", 64'(sentCount), 64'd5);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t5_valid_drop", 64'(validOrderedSets), 64'd0);
        chk("t5_idle", 64'(busy), 64'd0);
        chk("t5_count", 64'(sentCount), 64'd5);
        for (int i = 0; i < 3; i++) begin
            sawFinish = sawFinish | finish;
            tick();
        end
        chk("t5_no_finish", 64'(sawFinish), 64'd0);

        // 6: asynchronous reset mid-burst, then a fresh burst
        Gen = 3'd1; osType = 2'd0; numToSend = 16'd10; numberOfDetectedLanes = 5'd4;
        txReady = 1'b1;
        pushN(3, 2'd0);
        launch();
        tick();
        tick();
        tick();
        txReady = 1'b0;
        chk("t6_count_pre", 64'(sentCount), 64'd3);
        #1 reset = 1'b0;
        #1;
        chk("t6_rst_sets", 64'(orderedSets != '0), 64'd0);
        chk("t6_rst_valid", 64'(validOrderedSets), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_count", 64'(sentCount), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        Gen = 3'd2; osType = 2'd3; numToSend = 16'd2; numberOfDetectedLanes = 5'd16;
        txReady = 1'b1;
        pushN(2, 2'd3);
        launch();
        chk("t6_new_count0", 64'(sentCount), 64'd0);
        tick();
        chk("t6_new_count1", 64'(sentCount), 64'd1);
        tick();
        chk("t6_new_finish", 64'(finish), 64'd1);
        chk("t6_new_count2", 64'(sentCount), 64'd2);
        chk("t6_queue_empty", 64'(expQ.size()), 64'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
